line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 The module SHALL have parameter NBIT, default 8, meaning pixel width in bits.
REQ-002 The module SHALL have parameter KERNEL_SIZE, default 3, meaning window side in pixels.
REQ-003 The module SHALL have parameter IMG_WIDTH, default 640, meaning pixels per line.
REQ-004 The module SHALL have parameter IMG_HEIGHT, default 480, meaning lines per frame.
REQ-005 The module SHALL have port i_clk, input, 1, the single clock; all logic rising-edge.
REQ-006 The module SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 The module SHALL have port i_pixel, input, NBIT, incoming raster-order pixel.
REQ-008 The module SHALL have port i_pixel_valid, input, 1, which qualifies i_pixel; no backpressure.
REQ-009 The module SHALL have port i_sof, input, 1, start-of-frame; meaningful only with i_pixel_valid.
REQ-010 The module SHALL have port o_window, output, [KERNEL_SIZE][KERNEL_SIZE] x NBIT, the window feeding conv_block i_data.
REQ-011 The module SHALL have port o_window_valid, output, 1, feeding conv_block i_data_valid.
REQ-012 The module SHALL have port o_frame_done, output, 1, one-cycle pulse after the last pixel of a frame.

Function
REQ-013 The module SHALL accept a pixel on every rising edge where i_pixel_valid=1; nothing changes on other edges except o_window_valid/o_frame_done clearing.
REQ-014 The module SHALL keep column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) of the next pixel; col wraps to 0 and row increments at line end; row wraps to 0 after (IMG_HEIGHT-1, IMG_WIDTH-1).
REQ-015 The module SHALL hold KERNEL_SIZE-1 line buffers of IMG_WIDTH x NBIT (inferable RAM, read-before-write at address col).
REQ-016 On accept, the new column vector SHALL be {line pixels (row-K+1..row-1, col), i_pixel}, shifted into the window from the right; buffers shift down one line at address col.
REQ-017 o_window[0][0] SHALL be the oldest row and oldest column; o_window[K-1][K-1] SHALL be the pixel just accepted.
REQ-018 o_window_valid SHALL be 1 for exactly the cycle after an accept with row>=K-1 and col>=K-1 (latency 1, no padding); otherwise 0.
REQ-019 o_window SHALL be registered and hold its value between accepts.
REQ-020 An accept with i_sof=1 SHALL be treated as pixel (0,0): counters forced, window validity restarts; line buffer contents need not be cleared.
REQ-021 o_frame_done SHALL pulse 1 cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1), coincident with that window's valid.
REQ-022 Frames SHALL run back-to-back with no idle cycles required.

Reset
REQ-023 While i_rst_n=0: col=0, row=0, o_window all zeros, o_window_valid=0, o_frame_done=0; line buffer RAM is not reset.
REQ-024 Reset asserted mid-frame SHALL abort the frame; the first accept after release is pixel (0,0) regardless of i_sof.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, KERNEL_SIZE=3, NBIT=8, pixel = row*8+col)
REQ-025 Continuous frame from reset -> first o_window_valid one cycle after pixel 18; window rows {0,1,2},{8,9,10},{16,17,18}.
REQ-026 Same frame -> exactly 24 valids; last window {29,30,31},{37,38,39},{45,46,47} with o_frame_done=1 in the same cycle.
REQ-027 i_pixel_valid dropped for 3 cycles after pixel 20 -> no valids during gap, o_window holds {2,3,4},{10,11,12},{18,19,20}; next window after pixel 21 is {3,4,5},{11,12,13},{19,20,21}.
REQ-028 i_sof with pixel 0 asserted after pixel 30 of a frame -> no valid until pixel 18 of the new frame, then contents equal REQ-025.
REQ-029 i_rst_n low for 2 cycles after pixel 27 -> outputs zero immediately (asynchronous); restarted frame reproduces REQ-025 and REQ-026.
REQ-030 Two back-to-back frames, the second being pixel+100 -> 48 valids total, two o_frame_done pulses; first window of frame 2 {100,101,102},{108,109,110},{116,117,118}.

Source files
------------

// File: rtl/line_window_buffer.sv
`default_nettype none
// =============================================================================
// Module      : line_window_buffer
// Description : Raster-order pixel stream to KERNEL_SIZE x KERNEL_SIZE sliding
//               window, using KERNEL_SIZE-1 line RAMs (KERNEL_SIZE >= 2).
// Revision    : 1.0 - initial release
// =============================================================================
module line_window_buffer #(
    parameter int NBIT        = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic [NBIT-1:0]                               i_pixel,
    input  logic                                          i_pixel_valid,
    input  logic                                          i_sof,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] o_window,
    output logic                                          o_window_valid,
    output logic                                          o_frame_done
);

    localparam int c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST  = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(IMG_HEIGHT - 1);
    localparam logic [c_COL_W-1:0] c_COL_FIRST = c_COL_W'(KERNEL_SIZE - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_FIRST = c_ROW_W'(KERNEL_SIZE - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;

    logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][NBIT-1:0] r_window;
    logic                                              r_window_valid;
    logic                                              r_frame_done;

    // Column vector entering the window: index 0 is the oldest line.
    logic [NBIT-1:0] w_col_vec [KERNEL_SIZE];

    // Start-of-frame overrides the counters for this very accept.
    assign w_col = i_sof ? '0 : r_col;
    assign w_row = i_sof ? '0 : r_row;

    assign w_col_vec[KERNEL_SIZE-1] = i_pixel;

    generate
        for (genvar j = 0; j < KERNEL_SIZE - 1; j++) begin : g_line
            logic [NBIT-1:0] r_mem [IMG_WIDTH];

            // Read-before-write: each line moves down one slot at address col.
            always_ff @(posedge i_clk) begin
                if (i_pixel_valid) begin
                    r_mem[w_col] <= w_col_vec[j+1];
                end
            end

            assign w_col_vec[j] = r_mem[w_col];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_pixel_valid) begin
            if (w_col == c_COL_LAST) begin
                r_col <= '0;
                r_row <= (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
            end else begin
                r_col <= w_col + 1'b1;
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window <= '0;
        end else if (i_pixel_valid) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
                    r_window[r][c] <= r_window[r][c+1];
                end
                r_window[r][KERNEL_SIZE-1] <= w_col_vec[r];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window_valid <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_window_valid <= i_pixel_valid && (w_row >= c_ROW_FIRST) && (w_col >= c_COL_FIRST);
            r_frame_done   <= i_pixel_valid && (w_row == c_ROW_LAST) && (w_col == c_COL_LAST);
        end
    end

    assign o_window       = r_window;
    assign o_window_valid = r_window_valid;
    assign o_frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// =============================================================================
// Module      : tb_line_window_buffer
// Description : Self-checking bench for line_window_buffer (8x6 image, 3x3 window).
// Revision    : 1.0 - initial release
// =============================================================================
module tb_line_window_buffer;

    localparam int NBIT = 8;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int H    = 6;

    logic                             i_clk         = 1'b0;
    logic                             i_rst_n       = 1'b0;
    logic [NBIT-1:0]                  i_pixel       = '0;
    logic                             i_pixel_valid = 1'b0;
    logic                             i_sof         = 1'b0;
    logic [K-1:0][K-1:0][NBIT-1:0]    o_window;
    logic                             o_window_valid;
    logic                             o_frame_done;

    line_window_buffer #(
        .NBIT        (NBIT),
        .KERNEL_SIZE (K),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_pixel        (i_pixel),
        .i_pixel_valid  (i_pixel_valid),
        .i_sof          (i_sof),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .o_frame_done   (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: the current frame as a 2D image plus the raster position.
    int                            img [H][W];
    int                            pos_r = 0;
    int                            pos_c = 0;
    logic [K-1:0][K-1:0][NBIT-1:0] exp_win = '0;
    bit                            win_known = 1'b1;
    int                            valid_seen = 0;
    int                            done_seen  = 0;

    logic [71:0] c_first, c_last, c_gap, c_next, c_f2;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input int px, input bit sof);
        bit ev;
        bit ed;
        i_pixel_valid = v;
        i_pixel       = NBIT'(px);
        i_sof         = sof;
        @(posedge i_clk);
        #1;
        ev = 1'b0;
        ed = 1'b0;
        if (v) begin
            if (sof) begin
                pos_r = 0;
                pos_c = 0;
            end
            img[pos_r][pos_c] = px & 255;
            ev = (pos_r >= K - 1) && (pos_c >= K - 1);
            ed = (pos_r == H - 1) && (pos_c == W - 1);
            if (ev) begin
                for (int i = 0; i < K; i++)
                    for (int j = 0; j < K; j++)
                        exp_win[i][j] = NBIT'(img[pos_r-K+1+i][pos_c-K+1+j]);
            end
            win_known = ev;
            pos_c++;
            if (pos_c == W) begin
                pos_c = 0;
                pos_r++;
                if (pos_r == H) pos_r = 0;
            end
        end
        chk("valid", o_window_valid, ev);
        chk("frame_done", o_frame_done, ed);
        if (win_known) chk(ev ? "window" : "window_hold", o_window, exp_win);
        if (o_window_valid) valid_seen++;
        if (o_frame_done) done_seen++;
    endtask

    task automatic do_reset();
        #2;
        i_rst_n       = 1'b0;
        i_pixel_valid = 1'b0;
        i_sof         = 1'b0;
        #1;
        chk("rst_window", o_window, '0);
        chk("rst_valid", o_window_valid, 1'b0);
        chk("rst_done", o_frame_done, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n   = 1'b1;
        pos_r     = 0;
        pos_c     = 0;
        exp_win   = '0;
        win_known = 1'b1;
    endtask

    initial begin
        c_first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
        c_last  = {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29};
        c_gap   = {8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10, 8'd4, 8'd3, 8'd2};
        c_next  = {8'd21, 8'd20, 8'd19, 8'd13, 8'd12, 8'd11, 8'd5, 8'd4, 8'd3};
        c_f2    = {8'd118, 8'd117, 8'd116, 8'd110, 8'd109, 8'd108, 8'd102, 8'd101, 8'd100};

        // Reset state
        #3;
        chk("init_window", o_window, '0);
        chk("init_valid", o_window_valid, 1'b0);
        chk("init_done", o_frame_done, 1'b0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        step(1'b0, 0, 1'b0);

        // Continuous frame from reset
        valid_seen = 0;
        done_seen  = 0;
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, p, 1'b0);
            if (p == 18) chk("first_window", o_window, c_first);
            if (p == 47) chk("last_window", o_window, c_last);
        end
        chk("valid_count_f1", valid_seen, 24);
        chk("done_count_f1", done_seen, 1);

        // Input gap of 3 cycles after pixel 20
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, p, p == 0);
            if (p == 20) begin
                chk("pre_gap_window", o_window, c_gap);
                repeat (3) step(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                chk("gap_hold_window", o_window, c_gap);
            end
            if (p == 21) chk("post_gap_window", o_window, c_next);
        end

        // Start-of-frame after pixel 30 aborts the frame
        for (int p = 0; p <= 30; p++) step(1'b1, p, p == 0);
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, p, p == 0);
            if (p == 18) chk("sof_first_window", o_window, c_first);
        end

        // Reset mid-frame after pixel 27, then a clean frame without sof
        for (int p = 0; p <= 27; p++) step(1'b1, p, p == 0);
        do_reset();
        valid_seen = 0;
        done_seen  = 0;
        for (int p = 0; p < W * H; p++) begin
            step(1'b1, p, 1'b0);
            if (p == 18) chk("rst_first_window", o_window, c_first);
            if (p == 47) chk("rst_last_window", o_window, c_last);
        end
        chk("valid_count_rst", valid_seen, 24);
        chk("done_count_rst", done_seen, 1);

        // Two back-to-back frames, second offset by 100
        valid_seen = 0;
        done_seen  = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < W * H; p++) begin
                step(1'b1, p + 100 * f, p == 0);
                if (f == 1 && p == 18) chk("f2_first_window", o_window, c_f2);
            end
        end
        chk("valid_count_b2b", valid_seen, 48);
        chk("done_count_b2b", done_seen, 2);

        // Random pixels, random input gaps, occasional stray sof
        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < W * H; p++) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
                step(1'b1, int'($urandom_range(0, 255)), (p == 0) || ($urandom_range(0, 80) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
